alu8_seq: RTL and testbench

- Multi-cycle instruction sequencer for the 8-bit ALU datapath in the mini CPU.
- Accepts one byte-oriented, PIC16-style operation at a time and reads the file-register operand.
- Drives all ALU select and operand lines, then writes the result back to W or the file register.
- Owns the W register and the STATUS flags C, DC and Z.

---
 rtl/alu8_seq_pkg.sv | 56 +++++
 rtl/alu8_seq_decode.sv | 49 ++++
 rtl/alu8_seq.sv | 159 +++++++++++++++
 tb/tb_alu8_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_seq_pkg.sv
// rtl/alu8_seq_pkg.sv - shared types and encodings for the ALU instruction sequencer
package alu8_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WRIT = 2'd3
    } state_t;

    localparam logic [3:0] OP_MOVF  = 4'h0;
    localparam logic [3:0] OP_MOVWF = 4'h1;
    localparam logic [3:0] OP_CLRF  = 4'h2;
    localparam logic [3:0] OP_CLRW  = 4'h3;
    localparam logic [3:0] OP_SWAPF = 4'h4;
    localparam logic [3:0] OP_RLF   = 4'h5;
    localparam logic [3:0] OP_RRF   = 4'h6;
    localparam logic [3:0] OP_IORWF = 4'h7;
    localparam logic [3:0] OP_ANDWF = 4'h8;
    localparam logic [3:0] OP_XORWF = 4'h9;
    localparam logic [3:0] OP_COMF  = 4'hA;
    localparam logic [3:0] OP_ADDWF = 4'hB;
    localparam logic [3:0] OP_SUBWF = 4'hC;
    localparam logic [3:0] OP_INCF  = 4'hD;
    localparam logic [3:0] OP_DECF  = 4'hE;
    localparam logic [3:0] OP_NOP   = 4'hF;

    // ALU output mux
    localparam logic [1:0] OM_PASS  = 2'd0;
    localparam logic [1:0] OM_SHIFT = 2'd1;
    localparam logic [1:0] OM_LOGIC = 2'd2;
    localparam logic [1:0] OM_ADD   = 2'd3;

    // logic unit select
    localparam logic [1:0] LS_IOR = 2'd0;
    localparam logic [1:0] LS_AND = 2'd1;
    localparam logic [1:0] LS_XOR = 2'd2;
    localparam logic [1:0] LS_COM = 2'd3;

    // adder operand select
    localparam logic [1:0] AS_ADD = 2'd0;
    localparam logic [1:0] AS_SUB = 2'd1;
    localparam logic [1:0] AS_INC = 2'd2;
    localparam logic [1:0] AS_DEC = 2'd3;

    typedef struct packed {
        logic       clr;
        logic       swap_n_mov;
        logic       rlf_n_rrf;
        logic       sub;
        logic [1:0] op_mux_l;
        logic [1:0] op_mux_a;
        logic [1:0] out_mux;
    } alu_ctl_t;

endpackage

// File: rtl/alu8_seq_decode.sv
// rtl/alu8_seq_decode.sv - opcode to ALU control and write/flag-enable decode
module alu8_decode
    import alu8_seq_pkg::*;
(
    input  logic [3:0] op,
    input  logic       d,
    output alu_ctl_t   ctl,
    output logic       wr_w,
    output logic       wr_f,
    output logic       upd_c,
    output logic       upd_dc,
    output logic       upd_z
);

    // Default is a pass-through with destination chosen by d and no flag update.
    always_comb begin
        ctl    = '0;
        wr_w   = ~d;
        wr_f   = d;
        upd_c  = 1'b0;
        upd_dc = 1'b0;
        upd_z  = 1'b0;
        case (op)
            OP_MOVF:  upd_z = 1'b1;
            OP_MOVWF: begin wr_w = 1'b0; wr_f = 1'b1; end
            OP_CLRF:  begin ctl.clr = 1'b1; wr_w = 1'b0; wr_f = 1'b1; upd_z = 1'b1; end
            OP_CLRW:  begin ctl.clr = 1'b1; wr_w = 1'b1; wr_f = 1'b0; upd_z = 1'b1; end
            OP_SWAPF: ctl.swap_n_mov = 1'b1;
            OP_RLF:   begin ctl.out_mux = OM_SHIFT; ctl.rlf_n_rrf = 1'b1; upd_c = 1'b1; end
            OP_RRF:   begin ctl.out_mux = OM_SHIFT; upd_c = 1'b1; end
            OP_IORWF: begin ctl.out_mux = OM_LOGIC; ctl.op_mux_l = LS_IOR; upd_z = 1'b1; end
            OP_ANDWF: begin ctl.out_mux = OM_LOGIC; ctl.op_mux_l = LS_AND; upd_z = 1'b1; end
            OP_XORWF: begin ctl.out_mux = OM_LOGIC; ctl.op_mux_l = LS_XOR; upd_z = 1'b1; end
            OP_COMF:  begin ctl.out_mux = OM_LOGIC; ctl.op_mux_l = LS_COM; upd_z = 1'b1; end
            OP_ADDWF: begin
                ctl.out_mux = OM_ADD; ctl.op_mux_a = AS_ADD;
                upd_c = 1'b1; upd_dc = 1'b1; upd_z = 1'b1;
            end
            OP_SUBWF: begin
                ctl.out_mux = OM_ADD; ctl.op_mux_a = AS_SUB; ctl.sub = 1'b1;
                upd_c = 1'b1; upd_dc = 1'b1; upd_z = 1'b1;
            end
            OP_INCF:  begin ctl.out_mux = OM_ADD; ctl.op_mux_a = AS_INC; upd_z = 1'b1; end
            OP_DECF:  begin ctl.out_mux = OM_ADD; ctl.op_mux_a = AS_DEC; ctl.sub = 1'b1; upd_z = 1'b1; end
            default:  begin wr_w = 1'b0; wr_f = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu8_seq.sv
// rtl/alu8_seq.sv - multi-cycle sequencer driving the 8-bit ALU, owns W and STATUS
module alu8_seq
    import alu8_seq_pkg::*;
#(
    parameter int          ADDR_W = 7,
    parameter logic [7:0]  W_RST  = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic              cmd_d,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic [ADDR_W-1:0] f_rd_addr,
    input  logic [7:0]        f_rd_data,
    output logic              f_wr_en,
    output logic [ADDR_W-1:0] f_wr_addr,
    output logic [7:0]        f_wr_data,
    output logic              alu_clr,
    output logic              alu_swap_n_mov,
    output logic              alu_rlf_n_rrf,
    output logic              alu_sub,
    output logic [1:0]        alu_op_mux_l,
    output logic [1:0]        alu_op_mux_a,
    output logic [1:0]        alu_out_mux,
    output logic              alu_c_in,
    output logic [7:0]        alu_op_a1,
    output logic [7:0]        alu_op_b1,
    output logic [7:0]        alu_op_a,
    output logic [7:0]        alu_op_b,
    input  logic [7:0]        alu_out,
    input  logic              alu_c_new,
    input  logic              alu_dc_new,
    input  logic              alu_z_new,
    output logic [7:0]        w_reg,
    output logic              c_flag,
    output logic              dc_flag,
    output logic              z_flag,
    output logic              done
);

    state_t            state, state_nxt;
    logic [3:0]        op_q;
    logic              d_q;
    logic [ADDR_W-1:0] addr_q;
    alu_ctl_t          dec_ctl, ctl_q;
    logic              wr_w, wr_f, upd_c, upd_dc, upd_z;
    logic [7:0]        res_q;
    logic              c_res, dc_res, z_res;

    alu8_decode u_decode (
        .op     (op_q),
        .d      (d_q),
        .ctl    (dec_ctl),
        .wr_w   (wr_w),
        .wr_f   (wr_f),
        .upd_c  (upd_c),
        .upd_dc (upd_dc),
        .upd_z  (upd_z)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-state strobes; every op walks the full four-state loop.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        f_wr_en   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_READ;
            end
            S_READ: state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_WRIT;
            S_WRIT: begin
                done      = 1'b1;
                f_wr_en   = wr_f;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the accepted command; it stays stable for the rest of the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NOP;
            d_q    <= 1'b0;
            addr_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            op_q   <= cmd_op;
            d_q    <= cmd_d;
            addr_q <= cmd_addr;
        end
    end

    // Register ALU controls during READ so they are settled when operand data arrives in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               ctl_q <= '0;
        else if (state == S_READ) ctl_q <= dec_ctl;
    end

    // Capture ALU result and flags at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= 8'h00;
            c_res  <= 1'b0;
            dc_res <= 1'b0;
            z_res  <= 1'b0;
        end else if (state == S_EXEC) begin
            res_q  <= alu_out;
            c_res  <= alu_c_new;
            dc_res <= alu_dc_new;
            z_res  <= alu_z_new;
        end
    end

    // Retire: write W and the enabled flags in WRIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg   <= W_RST;
            c_flag  <= 1'b0;
            dc_flag <= 1'b0;
            z_flag  <= 1'b0;
        end else if (state == S_WRIT) begin
            if (wr_w)   w_reg   <= res_q;
            if (upd_c)  c_flag  <= c_res;
            if (upd_dc) dc_flag <= dc_res;
            if (upd_z)  z_flag  <= z_res;
        end
    end

    assign f_rd_addr      = addr_q;
    assign f_wr_addr      = addr_q;
    assign f_wr_data      = res_q;

    assign alu_clr        = ctl_q.clr;
    assign alu_swap_n_mov = ctl_q.swap_n_mov;
    assign alu_rlf_n_rrf  = ctl_q.rlf_n_rrf;
    assign alu_sub        = ctl_q.sub;
    assign alu_op_mux_l   = ctl_q.op_mux_l;
    assign alu_op_mux_a   = ctl_q.op_mux_a;
    assign alu_out_mux    = ctl_q.out_mux;
    assign alu_c_in       = c_flag;

    // MOVWF routes W through the pass path, so only a1 switches source.
    assign alu_op_a1      = (op_q == OP_MOVWF) ? w_reg : f_rd_data;
    assign alu_op_a       = f_rd_data;
    assign alu_op_b1      = w_reg;
    assign alu_op_b       = w_reg;

endmodule

// File: tb/tb_alu8_seq.sv
// tb/tb_alu8_seq.sv - self-checking bench for alu8_seq with file RAM, ALU and reference model
module tb_alu8_seq;
    import alu8_seq_pkg::*;

    localparam int         AW = 7;
    localparam logic [7:0] WR = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_d;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_addr, f_rd_addr, f_wr_addr;
    logic [7:0]    f_rd_data, f_wr_data;
    logic          f_wr_en;
    logic          alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub, alu_c_in;
    logic [1:0]    alu_op_mux_l, alu_op_mux_a, alu_out_mux;
    logic [7:0]    alu_op_a1, alu_op_b1, alu_op_a, alu_op_b, alu_out;
    logic          alu_c_new, alu_dc_new, alu_z_new;
    logic [7:0]    w_reg;
    logic          c_flag, dc_flag, z_flag, done;

    alu8_seq #(.ADDR_W(AW), .W_RST(WR)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_d(cmd_d), .cmd_addr(cmd_addr),
        .f_rd_addr(f_rd_addr), .f_rd_data(f_rd_data),
        .f_wr_en(f_wr_en), .f_wr_addr(f_wr_addr), .f_wr_data(f_wr_data),
        .alu_clr(alu_clr), .alu_swap_n_mov(alu_swap_n_mov), .alu_rlf_n_rrf(alu_rlf_n_rrf), .alu_sub(alu_sub),
        .alu_op_mux_l(alu_op_mux_l), .alu_op_mux_a(alu_op_mux_a), .alu_out_mux(alu_out_mux),
        .alu_c_in(alu_c_in),
        .alu_op_a1(alu_op_a1), .alu_op_b1(alu_op_b1), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_out(alu_out), .alu_c_new(alu_c_new), .alu_dc_new(alu_dc_new), .alu_z_new(alu_z_new),
        .w_reg(w_reg), .c_flag(c_flag), .dc_flag(dc_flag), .z_flag(z_flag), .done(done)
    );

    always #5 clk = ~clk;

    // File RAM: synchronous read, write-before-read, plus a bench preload port.
    logic [7:0]    mem [0:127];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [7:0]    tb_wdata = 8'h00;
    always @(posedge clk) begin
        if (tb_we)        mem[tb_waddr] <= tb_wdata;
        else if (f_wr_en) mem[f_wr_addr] <= f_wr_data;
        f_rd_data <= (f_wr_en && f_wr_addr == f_rd_addr) ? f_wr_data : mem[f_rd_addr];
    end

    // Event counters, read as deltas by the checking code.
    int wr_total = 0;
    int acc_total = 0;
    always @(posedge clk) begin
        if (f_wr_en) wr_total <= wr_total + 1;
        if (cmd_valid && cmd_ready) acc_total <= acc_total + 1;
    end

    // Behavioural ALU responding to the sequencer's control lines.
    logic [7:0] ax;
    logic [8:0] as;
    logic [4:0] ah;
    always_comb begin
        ax = 8'h00; as = 9'h000; ah = 5'h00;
        alu_out = 8'h00; alu_c_new = 1'b0; alu_dc_new = 1'b0;
        case (alu_out_mux)
            2'd0: alu_out = alu_clr ? 8'h00 : (alu_swap_n_mov ? {alu_op_a1[3:0], alu_op_a1[7:4]} : alu_op_a1);
            2'd1: begin
                alu_out   = alu_rlf_n_rrf ? {alu_op_a[6:0], alu_c_in} : {alu_c_in, alu_op_a[7:1]};
                alu_c_new = alu_rlf_n_rrf ? alu_op_a[7] : alu_op_a[0];
            end
            2'd2: case (alu_op_mux_l)
                2'd0:    alu_out = alu_op_a | alu_op_b;
                2'd1:    alu_out = alu_op_a & alu_op_b;
                2'd2:    alu_out = alu_op_a ^ alu_op_b;
                default: alu_out = ~alu_op_a;
            endcase
            default: begin
                ax = alu_op_mux_a[1] ? 8'h01 : alu_op_b;
                if (alu_sub) begin
                    as = {1'b0, alu_op_a} + {1'b0, ~ax} + 9'd1;
                    ah = {1'b0, alu_op_a[3:0]} + {1'b0, ~ax[3:0]} + 5'd1;
                end else begin
                    as = {1'b0, alu_op_a} + {1'b0, ax};
                    ah = {1'b0, alu_op_a[3:0]} + {1'b0, ax[3:0]};
                end
                alu_out = as[7:0]; alu_c_new = as[8]; alu_dc_new = ah[4];
            end
        endcase
    end
    assign alu_z_new = (alu_out == 8'h00);

    // Reference state: instruction-level view of W, STATUS and the file.
    logic [7:0] shadow [0:127];
    logic [7:0] mw = WR;
    bit mc = 0, mdc = 0, mz = 0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_op(input logic [3:0] op, input bit d, input int a, output bit fw);
        int f, w, r;
        bit to_f, uz, nop, oc;
        f = shadow[a]; w = mw; r = 0; to_f = d; uz = 0; nop = 0; oc = mc;
        case (op)
            OP_MOVF:  begin r = f; uz = 1; end
            OP_MOVWF: begin r = w; to_f = 1; end
            OP_CLRF:  begin r = 0; to_f = 1; uz = 1; end
            OP_CLRW:  begin r = 0; to_f = 0; uz = 1; end
            OP_SWAPF: r = (f % 16) * 16 + f / 16;
            OP_RLF:   begin r = (f * 2 + oc) % 256; mc = (f >= 128); end
            OP_RRF:   begin r = oc * 128 + f / 2; mc = (f % 2 == 1); end
            OP_IORWF: begin r = f | w; uz = 1; end
            OP_ANDWF: begin r = f & w; uz = 1; end
            OP_XORWF: begin r = f ^ w; uz = 1; end
            OP_COMF:  begin r = 255 - f; uz = 1; end
            OP_ADDWF: begin r = (f + w) % 256; mc = (f + w > 255); mdc = (f % 16 + w % 16 > 15); uz = 1; end
            OP_SUBWF: begin r = (f - w + 256) % 256; mc = (f >= w); mdc = (f % 16 >= w % 16); uz = 1; end
            OP_INCF:  begin r = (f + 1) % 256; uz = 1; end
            OP_DECF:  begin r = (f + 255) % 256; uz = 1; end
            default:  nop = 1;
        endcase
        if (uz) mz = (r == 0);
        fw = 0;
        if (!nop) begin
            if (to_f) begin shadow[a] = 8'(r); fw = 1; end
            else      mw = 8'(r);
        end
    endtask

    task automatic preload(input int a, input logic [7:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = AW'(a); tb_wdata = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
        shadow[a] = v;
    endtask

    // Issue one command, then check timing and architectural state just after it retires.
    task automatic do_op(input logic [3:0] op, input bit d, input int a, input bit hold);
        int lat, wr0, acc0;
        bit fw;
        @(negedge clk);
        chk("ready_in_idle", cmd_ready, 1);
        cmd_op = op; cmd_d = d; cmd_addr = AW'(a); cmd_valid = 1'b1;
        wr0 = wr_total; acc0 = acc_total;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (hold) chk("busy_not_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        chk("done_latency", lat, 3);
        ref_op(op, d, a, fw);
        @(posedge clk); #1;
        chk("w_reg", w_reg, mw);
        chk("c_flag", c_flag, mc);
        chk("dc_flag", dc_flag, mdc);
        chk("z_flag", z_flag, mz);
        chk("file_data", mem[a], shadow[a]);
        chk("file_writes", wr_total - wr0, fw ? 1 : 0);
        chk("accepts", acc_total - acc0, 1);
        chk("done_pulse", done, 0);
    endtask

    task automatic set_w(input logic [7:0] v);
        preload(127, v);
        do_op(OP_MOVF, 0, 127, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0;
        logic [3:0] rop;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_d = 1'b0; cmd_addr = '0;
        #2;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_w", w_reg, WR);
        chk("rst_flags", {c_flag, dc_flag, z_flag}, 0);
        chk("rst_wr_en", f_wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_alu_ctl", {alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub, alu_op_mux_l, alu_op_mux_a, alu_out_mux}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 128; i++) preload(i, 8'($urandom));

        // ADDWF into W with a nibble carry
        preload(8'h20, 8'h01);
        set_w(8'h0F);
        do_op(OP_ADDWF, 0, 8'h20, 0);
        chk("addwf_w", w_reg, 8'h10);
        chk("addwf_cdz", {c_flag, dc_flag, z_flag}, 3'b010);

        // RLF then RRF on the same file register
        preload(8'h22, 8'h80);
        do_op(OP_RLF, 1, 8'h22, 0);
        chk("rlf_f", mem[8'h22], 8'h00);
        chk("rlf_c", c_flag, 1);
        do_op(OP_RRF, 1, 8'h22, 0);
        chk("rrf_f", mem[8'h22], 8'h80);
        chk("rrf_c", c_flag, 0);

        // SUBWF to file, equal operands
        preload(8'h21, 8'h05);
        set_w(8'h05);
        do_op(OP_SUBWF, 1, 8'h21, 0);
        chk("subwf_f", mem[8'h21], 8'h00);
        chk("subwf_zc", {z_flag, c_flag}, 2'b11);
        chk("subwf_w", w_reg, 8'h05);

        // Back-to-back with cmd_valid held through busy cycles
        set_w(8'hA5);
        do_op(OP_MOVWF, 1, 8'h23, 1);
        do_op(OP_CLRW, 0, 8'h23, 1);
        do_op(OP_MOVF, 0, 8'h23, 1);
        chk("b2b_w", w_reg, 8'hA5);
        chk("b2b_z", z_flag, 0);

        // NOP then SWAPF into W
        preload(8'h24, 8'h3C);
        do_op(OP_NOP, 0, 8'h24, 0);
        do_op(OP_SWAPF, 0, 8'h24, 0);
        chk("swapf_w", w_reg, 8'hC3);

        // Reset during EXEC of ADDWF to file
        set_w(8'h33);
        preload(8'h30, 8'h44);
        wr0 = wr_total;
        @(negedge clk);
        cmd_op = OP_ADDWF; cmd_d = 1'b1; cmd_addr = 7'h30; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_w", w_reg, WR);
        chk("midrst_flags", {c_flag, dc_flag, z_flag}, 0);
        chk("midrst_wr_en", f_wr_en, 0);
        chk("midrst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_no_write", wr_total - wr0, 0);
        chk("midrst_file", mem[8'h30], 8'h44);
        mw = WR; mc = 0; mdc = 0; mz = 0;

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 0) preload(i % 16, 8'($urandom));
            rop = 4'($urandom_range(0, 15));
            do_op(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 15), (i % 2) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
